mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_lane_fmt.sv | 34 +++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and constants for the MEM-stage access unit
package mem_access_unit_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } memState_t;

  // Last wait-counter value tolerated before the access is abandoned (16 WAIT cycles)
  localparam logic [3:0] MEM_TIMEOUT = 4'd15;

  // One enable per byte lane of the 32-bit data bus
  localparam int BE_WIDTH = 4;

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - byte-lane enables, store replication and load zero-extension
module mem_lane_fmt
  import mem_access_unit_pkg::*;
(
  input  logic                stByte,
  input  logic [1:0]          stOffset,
  input  logic [31:0]         stData,
  output logic [BE_WIDTH-1:0] stBe,
  output logic [31:0]         stLanes,
  input  logic                ldByte,
  input  logic [1:0]          ldOffset,
  input  logic [31:0]         ldWord,
  output logic [31:0]         ldData
);

  // Store side: word uses all lanes, byte selects one lane and copies the byte everywhere
  always_comb begin
    stBe    = {BE_WIDTH{1'b1}};
    stLanes = stData;
    if (stByte) begin
      stBe    = {{(BE_WIDTH-1){1'b0}}, 1'b1} << stOffset;
      stLanes = {4{stData[7:0]}};
    end
  end

  // Load side: byte loads pick the addressed lane and zero-extend it
  always_comb begin
    ldData = ldWord;
    if (ldByte) begin
      ldData = {24'd0, ldWord[{ldOffset, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data memory access sequencer with stall and timeout
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                PCSrcE2M,
  input  logic                RegWriteE2M,
  input  logic                MemtoRegE2M,
  input  logic                MemWriteM,
  input  logic                ByteM,
  input  logic [31:0]         ALUResultM,
  input  logic [31:0]         WriteDataM,
  output logic                dreq,
  output logic                dwe,
  output logic [31:0]         daddr,
  output logic [31:0]         dwdata,
  output logic [BE_WIDTH-1:0] dbe,
  input  logic                dack,
  input  logic [31:0]         drdata,
  output logic                PCSrcM,
  output logic                RegWriteM,
  output logic                MemtoRegM,
  output logic [31:0]         ReadDataM,
  output logic                StallM,
  output logic                MemFault
);

  memState_t state, nextState;

  logic [3:0]          waitCnt;
  logic                pcSrcHeld;
  logic                regWriteHeld;
  logic                memtoRegHeld;
  logic                byteHeld;
  logic [1:0]          offsetHeld;
  logic                access;
  logic                misaligned;
  logic [BE_WIDTH-1:0] fmtBe;
  logic [31:0]         fmtWdata;
  logic [31:0]         fmtRdata;

  assign access     = MemWriteM | MemtoRegE2M;
  assign misaligned = ~ByteM & (ALUResultM[1:0] != 2'b00);

  // Store formatting uses the live request; load formatting uses the lane captured at issue
  mem_lane_fmt uLaneFmt (
    .stByte   (ByteM),
    .stOffset (ALUResultM[1:0]),
    .stData   (WriteDataM),
    .stBe     (fmtBe),
    .stLanes  (fmtWdata),
    .ldByte   (byteHeld),
    .ldOffset (offsetHeld),
    .ldWord   (drdata),
    .ldData   (fmtRdata)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next state plus stall, fault and MEM/WB control outputs; reset silences everything
  always_comb begin
    nextState = state;
    StallM    = 1'b0;
    MemFault  = 1'b0;
    PCSrcM    = 1'b0;
    RegWriteM = 1'b0;
    MemtoRegM = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          // Hold the instruction in EX/MEM and send a bubble while memory is busy
          StallM    = 1'b1;
          nextState = misaligned ? FAULT : WAIT;
        end else begin
          PCSrcM    = PCSrcE2M;
          RegWriteM = RegWriteE2M;
          MemtoRegM = MemtoRegE2M;
        end
      end
      WAIT: begin
        StallM = 1'b1;
        if (dack)                         nextState = DONE;
        else if (waitCnt == MEM_TIMEOUT)  nextState = FAULT;
      end
      DONE: begin
        PCSrcM    = pcSrcHeld;
        RegWriteM = regWriteHeld;
        MemtoRegM = memtoRegHeld;
        nextState = IDLE;
      end
      FAULT: begin
        // Write-back is suppressed; branch decision still flows so fetch is not lost
        MemFault  = 1'b1;
        PCSrcM    = PCSrcE2M;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (reset) begin
      StallM    = 1'b0;
      MemFault  = 1'b0;
      PCSrcM    = 1'b0;
      RegWriteM = 1'b0;
      MemtoRegM = 1'b0;
    end
  end

  // Request bus, wait counter, captured control bits and load data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dreq         <= 1'b0;
      dwe          <= 1'b0;
      dbe          <= '0;
      daddr        <= '0;
      dwdata       <= '0;
      ReadDataM    <= '0;
      waitCnt      <= '0;
      pcSrcHeld    <= 1'b0;
      regWriteHeld <= 1'b0;
      memtoRegHeld <= 1'b0;
      byteHeld     <= 1'b0;
      offsetHeld   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (access && !misaligned) begin
            dreq         <= 1'b1;
            dwe          <= MemWriteM;
            daddr        <= {ALUResultM[31:2], 2'b00};
            dbe          <= fmtBe;
            dwdata       <= fmtWdata;
            waitCnt      <= '0;
            pcSrcHeld    <= PCSrcE2M;
            regWriteHeld <= RegWriteE2M;
            memtoRegHeld <= MemtoRegE2M;
            byteHeld     <= ByteM;
            offsetHeld   <= ALUResultM[1:0];
          end
        end
        WAIT: begin
          if (dack) begin
            dreq <= 1'b0;
            if (!dwe) ReadDataM <= fmtRdata;
          end else if (waitCnt == MEM_TIMEOUT) begin
            dreq <= 1'b0;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSrcE2M = 1'b0, RegWriteE2M = 1'b0, MemtoRegE2M = 1'b0;
  logic        MemWriteM = 1'b0, ByteM = 1'b0;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic        dreq, dwe;
  logic [31:0] daddr, dwdata;
  logic [3:0]  dbe;
  logic        dack = 1'b0;
  logic [31:0] drdata = '0;
  logic        PCSrcM, RegWriteM, MemtoRegM;
  logic [31:0] ReadDataM;
  logic        StallM, MemFault;

  int          nChecks = 0;
  int          nFails = 0;
  logic [31:0] modelRead = '0;

  mem_access_unit dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrcE2M    (PCSrcE2M),
    .RegWriteE2M (RegWriteE2M),
    .MemtoRegE2M (MemtoRegE2M),
    .MemWriteM   (MemWriteM),
    .ByteM       (ByteM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .dreq        (dreq),
    .dwe         (dwe),
    .daddr       (daddr),
    .dwdata      (dwdata),
    .dbe         (dbe),
    .dack        (dack),
    .drdata      (drdata),
    .PCSrcM      (PCSrcM),
    .RegWriteM   (RegWriteM),
    .MemtoRegM   (MemtoRegM),
    .ReadDataM   (ReadDataM),
    .StallM      (StallM),
    .MemFault    (MemFault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clearInputs();
    PCSrcE2M = 0; RegWriteE2M = 0; MemtoRegE2M = 0; MemWriteM = 0; ByteM = 0;
    ALUResultM = '0; WriteDataM = '0; dack = 0; drdata = '0;
  endtask

  // One memory access: nWait = cycles without dack before the acknowledging one (>=16: never)
  task automatic runAccess(input string name, input logic isStore, input logic isByte,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int nWait,
                           input logic rw, input logic pcs);
    logic        mtr, misal, timeout, completes;
    logic [3:0]  expBe;
    logic [31:0] expAddr, expWdata, expRead, oldRead;
    int          expStall, expDreq, endCyc, faultAt;
    int          stallCnt, dreqCnt, rwCnt, mtrCnt, pcsCnt, faultCnt, busBad, holdBad;
    mtr       = ~isStore;
    misal     = !isByte && (addr % 4 != 0);
    timeout   = !misal && nWait >= 16;
    completes = !misal && !timeout;
    expAddr   = addr - (addr % 4);
    expBe     = isByte ? 4'(1 << (addr % 4)) : 4'hF;
    expWdata  = isByte ? {24'd0, wdata[7:0]} * 32'h01010101 : wdata;
    expRead   = isByte ? ((rdata >> (8 * (addr % 4))) & 32'hFF) : rdata;
    expStall  = misal ? 1 : (timeout ? 17 : nWait + 2);
    expDreq   = misal ? 0 : (timeout ? 16 : nWait + 1);
    endCyc    = expStall;
    oldRead   = modelRead;
    stallCnt = 0; dreqCnt = 0; rwCnt = 0; mtrCnt = 0; pcsCnt = 0;
    faultCnt = 0; busBad = 0; holdBad = 0; faultAt = -1;
    for (int c = 0; c <= endCyc + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        PCSrcE2M = pcs; RegWriteE2M = rw; MemtoRegE2M = mtr; MemWriteM = isStore;
        ByteM = isByte; ALUResultM = addr; WriteDataM = wdata;
      end
      if (c >= endCyc) begin MemWriteM = 0; MemtoRegE2M = 0; RegWriteE2M = 0; end
      if (c == endCyc + 1) PCSrcE2M = 0;
      dack   = completes && (c == nWait + 1);
      drdata = dack ? rdata : $urandom();
      #1;
      if (StallM) stallCnt++;
      if (dreq) begin
        dreqCnt++;
        if (daddr !== expAddr || dbe !== expBe || dwdata !== expWdata || dwe !== isStore)
          busBad++;
      end
      if (c <= expDreq && ReadDataM !== oldRead) holdBad++;
      if (RegWriteM === 1'b1) rwCnt++;
      if (MemtoRegM === 1'b1) mtrCnt++;
      if (PCSrcM === 1'b1) pcsCnt++;
      if (MemFault === 1'b1) begin faultCnt++; faultAt = c; end
    end
    dack = 0;
    if (completes && !isStore) modelRead = expRead;

    nChecks++;
    if (stallCnt !== expStall) begin
      nFails++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, stallCnt, expStall);
    end
    nChecks++;
    if (dreqCnt !== expDreq) begin
      nFails++; $display("FAIL %s dreq_cycles: got %0d expected %0d", name, dreqCnt, expDreq);
    end
    nChecks++;
    if (busBad != 0) begin
      nFails++;
      $display("FAIL %s request_bus: %0d bad cycles, last daddr=%h dbe=%b dwdata=%h dwe=%b expected %h %b %h %b",
               name, busBad, daddr, dbe, dwdata, dwe, expAddr, expBe, expWdata, isStore);
    end
    nChecks++;
    if (faultCnt !== (completes ? 0 : 1) || (!completes && faultAt != endCyc)) begin
      nFails++;
      $display("FAIL %s mem_fault: got %0d pulses at cycle %0d expected %0d at cycle %0d",
               name, faultCnt, faultAt, completes ? 0 : 1, endCyc);
    end
    nChecks++;
    if (rwCnt !== (completes ? int'(rw) : 0) || mtrCnt !== (completes ? int'(mtr) : 0) ||
        pcsCnt !== int'(pcs)) begin
      nFails++;
      $display("FAIL %s writeback_pulses: got rw=%0d mtr=%0d pcs=%0d expected rw=%0d mtr=%0d pcs=%0d",
               name, rwCnt, mtrCnt, pcsCnt, completes ? int'(rw) : 0, completes ? int'(mtr) : 0, int'(pcs));
    end
    nChecks++;
    if (holdBad != 0 || ReadDataM !== modelRead) begin
      nFails++;
      $display("FAIL %s read_data: got %h (%0d early changes) expected %h", name, ReadDataM, holdBad, modelRead);
    end
  endtask

  task automatic test_reset();
    PCSrcE2M = 1; RegWriteE2M = 1; MemtoRegE2M = 1; ALUResultM = 32'h100; dack = 1;
    repeat (3) @(negedge clk);
    #1;
    nChecks++;
    if (dreq !== 0 || dwe !== 0 || dbe !== 0 || daddr !== 0 || dwdata !== 0 || ReadDataM !== 0 ||
        StallM !== 0 || MemFault !== 0 || PCSrcM !== 0 || RegWriteM !== 0 || MemtoRegM !== 0) begin
      nFails++;
      $display("FAIL reset_state: dreq=%b dwe=%b dbe=%b daddr=%h dwdata=%h rd=%h stall=%b fault=%b ctl=%b%b%b expected all 0",
               dreq, dwe, dbe, daddr, dwdata, ReadDataM, StallM, MemFault, PCSrcM, RegWriteM, MemtoRegM);
    end
    @(negedge clk);
    clearInputs();
    reset = 0;
  endtask

  task automatic test_alu_passthrough();
    int bad = 0;
    logic p, r;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      p = 1'($urandom()); r = (i == 0) ? 1'b1 : 1'($urandom());
      clearInputs();
      PCSrcE2M = p; RegWriteE2M = r; ALUResultM = $urandom(); WriteDataM = $urandom();
      ByteM = 1'($urandom());
      #1;
      if (PCSrcM !== p || RegWriteM !== r || MemtoRegM !== 0 || StallM !== 0 || dreq !== 0) bad++;
    end
    nChecks++;
    if (bad != 0) begin
      nFails++;
      $display("FAIL alu_passthrough: %0d bad cycles, last ctl=%b%b%b stall=%b dreq=%b expected %b%b0 0 0",
               bad, PCSrcM, RegWriteM, MemtoRegM, StallM, dreq, p, r);
    end
    @(negedge clk);
    clearInputs();
  endtask

  task automatic test_stray_dack();
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clearInputs();
      dack = 1; drdata = $urandom();
      #1;
      if (dreq !== 0 || StallM !== 0 || ReadDataM !== modelRead || MemFault !== 0) bad++;
    end
    @(negedge clk);
    dack = 0;
    #1;
    nChecks++;
    if (bad != 0 || ReadDataM !== modelRead) begin
      nFails++;
      $display("FAIL stray_dack: %0d bad cycles, ReadDataM=%h expected %h", bad, ReadDataM, modelRead);
    end
  endtask

  task automatic test_reset_mid_wait();
    int bad = 0;
    @(negedge clk);
    RegWriteE2M = 1; MemtoRegE2M = 1; ALUResultM = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    nChecks++;
    if (dreq !== 1 || ReadDataM !== modelRead) begin
      nFails++;
      $display("FAIL reset_mid_wait_pre: dreq=%b ReadDataM=%h expected 1 %h", dreq, ReadDataM, modelRead);
    end
    reset = 1;
    #1;
    nChecks++;
    if (dreq !== 0 || ReadDataM !== 0 || StallM !== 0 || RegWriteM !== 0 || MemtoRegM !== 0) begin
      nFails++;
      $display("FAIL reset_mid_wait: dreq=%b ReadDataM=%h stall=%b rw=%b mtr=%b expected 0 00000000 0 0 0",
               dreq, ReadDataM, StallM, RegWriteM, MemtoRegM);
    end
    @(negedge clk);
    clearInputs();
    reset = 0;
    modelRead = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dack = 1; drdata = 32'hFFFF_FFFF;
      #1;
      if (dreq !== 0 || RegWriteM !== 0 || MemtoRegM !== 0 || ReadDataM !== 0) bad++;
    end
    dack = 0;
    nChecks++;
    if (bad != 0) begin
      nFails++;
      $display("FAIL reset_no_writeback: %0d bad cycles after reset, ReadDataM=%h expected 00000000", bad, ReadDataM);
    end
  endtask

  task automatic test_random();
    logic        st, by;
    logic [31:0] addr;
    int          nw;
    for (int i = 0; i < 24; i++) begin
      st   = 1'($urandom());
      by   = 1'($urandom());
      addr = $urandom_range(0, 32'hFFFF);
      if (!by && $urandom_range(0, 3) != 0) addr = addr & ~32'd3;
      nw   = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 15);
      runAccess("random", st, by, addr, $urandom(), $urandom(), nw, 1'($urandom()), 1'($urandom()));
    end
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    runAccess("word_load",   0, 0, 32'h100, $urandom(), 32'hDEADBEEF, 3, 1, 0);
    runAccess("byte_store",  1, 1, 32'h203, 32'hABCD_125A, $urandom(), 2, 0, 0);
    runAccess("byte_load",   0, 1, 32'h102, $urandom(), 32'h11223344, 1, 1, 0);
    test_reset_mid_wait();
    runAccess("word_load_b", 0, 0, 32'h80, $urandom(), 32'hCAFE_F00D, 0, 1, 1);
    runAccess("timeout",     0, 0, 32'h104, $urandom(), $urandom(), 16, 1, 0);
    runAccess("last_wait",   0, 0, 32'h108, $urandom(), 32'h1357_9BDF, 15, 1, 0);
    runAccess("misaligned",  1, 0, 32'h006, $urandom(), $urandom(), 0, 0, 1);
    test_stray_dack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
